// File: rtl/risc8_pkg.sv
// risc8_pkg -- shared types and constants for the RISC8 interrupt controller.
//   e_intc_state    : controller FSM states (IDLE, REQ, SERV)
//   INTC_VEC_STRIDE : word distance between consecutive interrupt vectors
//   intc_vec()      : vector word address for a given source index (mod 256)
package risc8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } e_intc_state;

    localparam int INTC_VEC_STRIDE = 4;

    function automatic logic [7:0] intc_vec(input logic [7:0] base, input logic [2:0] idx);
        return base + 8'(INTC_VEC_STRIDE) * {5'b0, idx};
    endfunction

endpackage

// File: rtl/risc8_intc_prio.sv
// risc8_intc_prio -- combinational lowest-index-first priority encoder.
//   vec   in  N  request vector (already masked)
//   valid out 1  at least one bit of vec set
//   idx   out 3  index of the lowest set bit (0 when none)
module risc8_intc_prio #(
    parameter int N = 4
) (
    input  logic [N-1:0] vec,
    output logic         valid,
    output logic [2:0]   idx
);

    always_comb begin
        valid = |vec;
        idx   = 3'd0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/risc8_intc.sv
// risc8_intc -- vectored interrupt controller for the RISC8 core.
//   clk, rst_n       clock, async active-low reset
//   irq_src          level interrupt inputs (synchronous); rising edge raises pending
//   mask_we/wdata    mask register write (1 = enabled)
//   gie_set/gie_clr  global enable pulses (clear wins)
//   intr_req/ack     request handshake with the core
//   intr_id/vec      granted source and its vector word address
//   reti             core executed RETI
//   pend             pending flags
//   flags            GETIF word {gie, in_service, 3'b0, intr_id}
// Optional feature: define RISC8_INTC_NEST_EN to allow higher-priority
// sources to preempt a service in progress (nested interrupts).
module risc8_intc #(
    parameter int         N_IRQ    = 4,
    parameter logic [7:0] VEC_BASE = 8'h04
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             gie_set,
    input  logic             gie_clr,
    output logic             intr_req,
    input  logic             intr_ack,
    output logic [2:0]       intr_id,
    output logic [7:0]       intr_vec,
    input  logic             reti,
    output logic [N_IRQ-1:0] pend,
    output logic [7:0]       flags
);
    import risc8_pkg::*;

    e_intc_state      state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] pend_n;
    logic             gie;
    logic             cand_vld;
    logic [2:0]       cand_idx;
    logic             ack_take;
    logic             reti_take;
    logic             in_service;

    assign rise      = irq_src & ~irq_q;
    assign ack_take  = (state == REQ) && intr_ack;
    assign reti_take = (state == SERV) && reti;

    risc8_intc_prio #(.N(N_IRQ)) u_cand (
        .vec   (pend & mask),
        .valid (cand_vld),
        .idx   (cand_idx)
    );

    // Grant clears the serviced bit; a coincident rise on that source re-arms it.
    always_comb begin
        pend_n = pend;
        for (int i = 0; i < N_IRQ; i++) begin
            if (ack_take && intr_id == 3'(i)) pend_n[i] = 1'b0;
        end
        pend_n = pend_n | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
            mask  <= '0;
            pend  <= '0;
            gie   <= 1'b0;
        end else begin
            irq_q <= irq_src;
            pend  <= pend_n;
            if (mask_we) mask <= mask_wdata;
            if (ack_take || gie_clr)      gie <= 1'b0;
            else if (gie_set || reti_take) gie <= 1'b1;
        end
    end

`ifdef RISC8_INTC_NEST_EN
    // One bit per active service level; lowest set bit is the innermost level.
    logic [N_IRQ-1:0] in_svc;
    logic [N_IRQ-1:0] in_svc_set;
    logic [N_IRQ-1:0] in_svc_rest;
    logic             svc_vld;
    logic [2:0]       svc_idx;
    logic             rest_vld;
    logic [2:0]       rest_idx;

    always_comb begin
        in_svc_set = in_svc;
        for (int i = 0; i < N_IRQ; i++) begin
            if (intr_id == 3'(i)) in_svc_set[i] = 1'b1;
        end
    end

    // Drop the innermost level on reti.
    assign in_svc_rest = in_svc & (in_svc - N_IRQ'(1));

    risc8_intc_prio #(.N(N_IRQ)) u_svc (
        .vec   (in_svc),
        .valid (svc_vld),
        .idx   (svc_idx)
    );

    risc8_intc_prio #(.N(N_IRQ)) u_rest (
        .vec   (in_svc_rest),
        .valid (rest_vld),
        .idx   (rest_idx)
    );

    assign in_service = svc_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            intr_req <= 1'b0;
            intr_id  <= 3'd0;
            intr_vec <= VEC_BASE;
            in_svc   <= '0;
        end else begin
            case (state)
                IDLE: if (gie && cand_vld) begin
                    state    <= REQ;
                    intr_req <= 1'b1;
                    intr_id  <= cand_idx;
                    intr_vec <= intc_vec(VEC_BASE, cand_idx);
                end
                REQ: if (intr_ack) begin
                    state    <= SERV;
                    intr_req <= 1'b0;
                    in_svc   <= in_svc_set;
                end else if (gie_clr) begin
                    intr_req <= 1'b0;
                    // A withdrawn preemption falls back to the level it interrupted.
                    if (svc_vld) begin
                        state    <= SERV;
                        intr_id  <= svc_idx;
                        intr_vec <= intc_vec(VEC_BASE, svc_idx);
                    end else begin
                        state <= IDLE;
                    end
                end
                SERV: if (reti) begin
                    in_svc <= in_svc_rest;
                    if (rest_vld) begin
                        intr_id  <= rest_idx;
                        intr_vec <= intc_vec(VEC_BASE, rest_idx);
                    end else begin
                        state <= IDLE;
                    end
                end else if (gie && cand_vld && cand_idx < intr_id) begin
                    state    <= REQ;
                    intr_req <= 1'b1;
                    intr_id  <= cand_idx;
                    intr_vec <= intc_vec(VEC_BASE, cand_idx);
                end
                default: begin
                    state    <= IDLE;
                    intr_req <= 1'b0;
                end
            endcase
        end
    end
`else
    assign in_service = (state == SERV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            intr_req <= 1'b0;
            intr_id  <= 3'd0;
            intr_vec <= VEC_BASE;
        end else begin
            case (state)
                IDLE: if (gie && cand_vld) begin
                    state    <= REQ;
                    intr_req <= 1'b1;
                    intr_id  <= cand_idx;
                    intr_vec <= intc_vec(VEC_BASE, cand_idx);
                end
                REQ: if (intr_ack) begin
                    state    <= SERV;
                    intr_req <= 1'b0;
                end else if (gie_clr) begin
                    state    <= IDLE;
                    intr_req <= 1'b0;
                end
                SERV: if (reti) state <= IDLE;
                default: begin
                    state    <= IDLE;
                    intr_req <= 1'b0;
                end
            endcase
        end
    end
`endif

    assign flags = {gie, in_service, 3'b000, intr_id};

endmodule

// File: doc/risc8_intc.md
RISC8_INTC -- requirements
Module: risc8_intc

Interface
REQ-001 SHALL have parameter N_IRQ, default 4, number of interrupt sources (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 8'h04, word address of vector 0.
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_src  in  N_IRQ  level inputs, already synchronous to clk; a rising edge raises a request.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  N_IRQ  new mask; 1 = enabled.
- gie_set  in  1  pulse that sets the global enable.
- gie_clr  in  1  pulse that clears the global enable.
- intr_req  out  1  request to core.
- intr_ack  in  1  core accepts request at an instruction boundary.
- intr_id  out  3  granted source index.
- intr_vec  out  8  word: VEC_BASE + 4*intr_id, modulo 256.
- reti  in  1  pulse, core executed RETI.
- pend  out  N_IRQ  pending flags.
- flags  out  8  GETIF word: {gie, in_service, 3'b0, intr_id}.

Function
REQ-004 SHALL register irq_src into irq_q; rise = irq_src & ~irq_q.
REQ-005 SHALL set pend[i] on rise[i] regardless of mask; pend[i] SHALL be cleared only when intr_ack grants i, and rise[i] in the same cycle SHALL win (pend[i] stays 1).
REQ-006 SHALL select the lowest-index bit of (pend & mask) as the candidate; index 0 SHALL be highest priority.
REQ-007 SHALL implement the FSM IDLE, REQ, SERV; intr_req SHALL be 1 only in REQ.
REQ-008 IDLE->REQ SHALL occur when gie=1 and a candidate exists; intr_id/intr_vec SHALL be loaded and then held frozen through REQ.
REQ-009 REQ->SERV SHALL occur on intr_ack; the same edge SHALL clear gie and pend[intr_id].
REQ-010 REQ->IDLE SHALL occur on gie_clr without ack; pend SHALL be unchanged, and ack in that same cycle SHALL take priority (go to SERV).
REQ-011 SERV->IDLE SHALL occur on reti; the same edge SHALL set gie=1.
REQ-012 reti outside SERV and intr_ack outside REQ SHALL be ignored.
REQ-013 Latency SHALL be as follows: rise sampled at edge k gives pend=1 after k; intr_req=1 after edge k+1 when gie and mask permit.
REQ-014 gie_set and gie_clr together SHALL resolve as clear.
REQ-015 mask_we SHALL take effect at the next edge and SHALL NOT affect a request already in REQ.

Reset
REQ-016 On rst_n low, the block SHALL be in state IDLE with gie=0, mask=0, pend=0, irq_q=0, intr_id=0, intr_vec=VEC_BASE, and intr_req=0, immediately and asynchronously.
REQ-017 Reset mid-REQ or mid-SERV SHALL discard all pending and in-service state.

Configuration
REQ-018 With RISC8_INTC_NEST_EN defined, the block SHALL allow nesting: in SERV, a candidate with index < current intr_id and gie=1 SHALL go to REQ. An in-service bitmask SHALL record active levels; reti SHALL clear the lowest set bit, and intr_id SHALL restore to the next set bit; the block SHALL return to IDLE only when the bitmask is empty.
REQ-019 Without RISC8_INTC_NEST_EN, the block SHALL support a single level only: in SERV, new requests SHALL stay pending until reti.

Structure
REQ-020 risc8_pkg SHALL hold the e_intc_state enum (IDLE, REQ, SERV) and localparam INTC_VEC_STRIDE = 4.
REQ-021 The priority encoder SHALL be a combinational sub-module, risc8_intc_prio, with masked vector in and {valid, index} out.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Reset, then gie_set, mask=4'hF, irq_src[2] rises -> intr_req 2 edges later, intr_id=2, intr_vec=8'h0C.
- irq_src=4'b1010 rising together -> intr_id=1 first; after ack and reti -> intr_id=3, vec=8'h10.
- Mask=4'b1110, irq_src[0] rises -> pend=4'b0001, no intr_req; mask_we 4'hF -> intr_req, id=0.
- In REQ, gie_clr -> intr_req=0 after edge, pend retained; gie_set -> intr_req returns.
- Ack cycle coincides with a new rise on the same source -> pend bit stays 1, second service follows the reti.
- RISC8_INTC_NEST_EN: in SERV id=3 with gie_set, irq 1 rises -> preempt, id=1; reti -> id=3; reti -> IDLE. Without the macro, the same stimulus produces no preemption.
